// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : Fetches bytes from an upstream FIFO and sends each one as an
//               8N1 UART frame, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       EN,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int                  c_BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_ONE = c_BAUD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } t_state;

  t_state              r_state;
  t_state              w_state_next;
  logic [c_BAUD_W-1:0] r_baud;
  logic [c_BAUD_W-1:0] w_baud_next;
  logic [2:0]          r_bit;
  logic [2:0]          w_bit_next;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_next;
  logic                r_tx;
  logic                w_tx_next;
  logic                r_rd;
  logic                w_rd_next;
  logic                r_done;
  logic                w_done_next;
  logic                w_bit_end;

  assign w_bit_end = (r_baud == c_BAUD_MAX);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_rd    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_rd    <= w_rd_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = 1'b1;
    w_rd_next    = 1'b0;
    w_done_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        if (EN && !fifo_empty) begin
          w_state_next = S_READ;
        end
      end
      S_READ: begin
        w_baud_next  = '0;
        w_state_next = S_LATCH;
      end
      S_LATCH: begin
        // FIFO read data is valid only in this cycle.
        w_baud_next  = '0;
        w_bit_next   = '0;
        w_shift_next = fifo_data;
        w_state_next = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + c_BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          w_bit_next  = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
          end
        end else begin
          w_baud_next = r_baud + c_BAUD_ONE;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = S_IDLE;
        end else begin
          w_baud_next = r_baud + c_BAUD_ONE;
        end
      end
      default: begin
        w_baud_next  = '0;
        w_bit_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    if (w_state_next == S_START) begin
      w_tx_next = 1'b0;
    end else if (w_state_next == S_DATA) begin
      w_tx_next = w_shift_next[w_bit_next];
    end
    w_rd_next   = (w_state_next == S_READ);
    w_done_next = (r_state == S_STOP) && (w_state_next == S_IDLE);
  end

  assign fifo_rd = r_rd;
  assign tx      = r_tx;
  assign tx_done = r_done;
  assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Randomized scoreboard bench: FIFO model feeds bytes, a
//               behavioural UART receiver decodes and compares each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       EN = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .EN         (EN),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 Clk = ~Clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  bit         noise = 1'b0;
  int         rd_count = 0;
  int         frames_started = 0;
  int         frames_done = 0;
  int         done_count = 0;
  int         last_gap = -1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO model: registered read data appears the cycle after fifo_rd.
  initial begin : fifo_drv
    bit rd_prev;
    forever begin
      @(negedge Clk);
      rd_prev = fifo_rd;
      @(posedge Clk);
      #1;
      if (rd_prev) begin
        rd_count++;
        if (fifo_q.size() == 0) begin
          check("rd_on_empty", 1, 0);
        end else begin
          fifo_data = fifo_q.pop_front();
          exp_q.push_back(fifo_data);
        end
      end else if (noise) begin
        fifo_data = 8'($urandom);
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Behavioural receiver and protocol monitor.
  initial begin : monitor
    int         cyc, s, trig, done_cyc, last_end, pos, bitn;
    bit         in_frame, prev_tx, prev_ok, shape_ok, lvl;
    logic [7:0] exp_b, rx;
    cyc = 0; s = 0; trig = -100; done_cyc = -1; last_end = -1;
    in_frame = 0; prev_tx = 1; prev_ok = 0; shape_ok = 1;
    exp_b = 0; rx = 0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (Rst) begin
        in_frame = 0;
        done_cyc = -1;
        prev_tx  = 1;
        prev_ok  = 0;
        continue;
      end
      if (cyc == done_cyc) begin
        check("tx_done_pulse", int'(tx_done), 1);
        if (tx_done) done_count++;
      end else if (tx_done) begin
        check("tx_done_spurious", 1, 0);
      end
      if (fifo_rd) check("rd_allowed", int'(prev_ok), 1);
      if (!in_frame && prev_tx && !tx) begin
        frames_started++;
        check("start_latency", cyc - trig, 3);
        if (last_end >= 0) last_gap = cyc - last_end - 1;
        if (exp_q.size() == 0) begin
          check("frame_expected", 0, 1);
          exp_b = 8'h00;
        end else begin
          exp_b = exp_q.pop_front();
        end
        in_frame = 1; s = cyc; shape_ok = 1; rx = 8'h00;
      end
      if (in_frame) begin
        pos  = cyc - s;
        bitn = pos / CPB;
        if (bitn == 0)      lvl = 1'b0;
        else if (bitn >= 9) lvl = 1'b1;
        else                lvl = exp_b[bitn-1];
        if (tx !== lvl || !busy) shape_ok = 0;
        if ((pos % CPB) == CPB / 2 && bitn >= 1 && bitn <= 8) rx[bitn-1] = tx;
        if (pos == 10 * CPB - 1) begin
          check("rx_byte", int'(rx), int'(exp_b));
          check("frame_shape", int'(shape_ok), 1);
          in_frame = 0;
          done_cyc = cyc + 1;
          last_end = cyc;
          frames_done++;
        end
      end
      prev_ok = !busy && EN && !fifo_empty;
      if (prev_ok) trig = cyc;
      prev_tx = tx;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input string name);
    int t = 0;
    while (frames_done < target && t < 3000) begin
      @(posedge Clk);
      t++;
    end
    #1;
    if (frames_done < target) check(name, frames_done, target);
  endtask

  task automatic wait_start(input int target, input string name);
    int t = 0;
    while (frames_started < target && t < 3000) begin
      @(posedge Clk);
      t++;
    end
    #1;
    if (frames_started < target) check(name, frames_started, target);
  endtask

  initial begin : stimulus
    Rst = 1'b1;
    EN  = 1'b1;
    cyc_wait(3);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_fifo_rd", int'(fifo_rd), 0);
    check("rst_tx_done", int'(tx_done), 0);
    Rst = 1'b0;

    cyc_wait(50);
    check("idle_tx", int'(tx), 1);
    check("idle_busy", int'(busy), 0);
    check("idle_rd_count", rd_count, 0);
    check("idle_frames", frames_started, 0);

    fifo_q.push_back(8'hA5);
    wait_frames(1, "a5_timeout");
    cyc_wait(3);
    check("a5_rd_count", rd_count, 1);
    check("a5_done_count", done_count, 1);

    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    wait_frames(3, "b2b_timeout");
    cyc_wait(3);
    check("b2b_gap", last_gap, 3);
    check("b2b_done_count", done_count, 3);
    check("b2b_rd_count", rd_count, 3);

    EN = 1'b0;
    fifo_q.push_back(8'h3C);
    cyc_wait(30);
    check("en0_rd_count", rd_count, 3);
    check("en0_frames", frames_started, 3);
    check("en0_tx", int'(tx), 1);
    EN = 1'b1;
    wait_start(4, "3c_start_timeout");
    cyc_wait(16);
    EN = 1'b0;
    fifo_q.push_back(8'h11);
    wait_frames(4, "3c_timeout");
    cyc_wait(30);
    check("en_drop_rd_count", rd_count, 4);
    check("en_drop_frames", frames_started, 4);
    EN = 1'b1;
    wait_frames(5, "11_timeout");
    cyc_wait(3);

    fifo_q.push_back(8'($urandom));
    fifo_q.push_back(8'($urandom));
    wait_start(6, "abort_start_timeout");
    cyc_wait(20);
    Rst = 1'b1;
    cyc_wait(1);
    Rst = 1'b0;
    @(negedge Clk);
    check("abort_tx", int'(tx), 1);
    check("abort_busy", int'(busy), 0);
    wait_frames(6, "after_abort_timeout");
    cyc_wait(3);
    check("abort_done_count", done_count, 6);

    noise = 1'b1;
    fifo_q.push_back(8'h5A);
    wait_frames(7, "5a_timeout");
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(8'($urandom));
      cyc_wait($urandom_range(0, 60));
    end
    wait_frames(15, "random_timeout");
    noise = 1'b0;
    cyc_wait(5);
    check("final_done_count", done_count, 15);
    check("final_rd_count", rd_count, 16);
    check("final_exp_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
